// File: rtl/demux_rr_if.sv
// ----------------------------------------------------------------------------
// demux_rr_if
//   Bundles the upstream word handshake and the per-lane downstream bus of the
//   1:N round-robin demultiplexer.
//
//   Signals
//     data_in   [DATA_W]        upstream word
//     valid_in                  upstream word present this cycle
//     ready_out                 at least one lane can take a word
//     pause_in  [N_OUT]         per-lane "do not deliver" request
//     data_out  [N_OUT*DATA_W]  flattened lanes, lane i at [i*DATA_W +: DATA_W]
//     valid_out [N_OUT]         one-hot (or zero) per-lane delivery strobe
//     sel_out   [PTR_W]         next preferred lane
//     word_cnt  [16]            saturating count of accepted words
//
//   Modports
//     master : upstream producer plus downstream consumers (drives inputs)
//     slave  : the demultiplexer itself
// ----------------------------------------------------------------------------
interface demux_rr_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 2
);
    localparam int PTR_W = (N_OUT > 2) ? $clog2(N_OUT) : 1;

    logic [DATA_W-1:0]       data_in;
    logic                    valid_in;
    logic                    ready_out;
    logic [N_OUT-1:0]        pause_in;
    logic [N_OUT*DATA_W-1:0] data_out;
    logic [N_OUT-1:0]        valid_out;
    logic [PTR_W-1:0]        sel_out;
    logic [15:0]             word_cnt;

    modport master (
        output data_in, valid_in, pause_in,
        input  ready_out, data_out, valid_out, sel_out, word_cnt
    );

    modport slave (
        input  data_in, valid_in, pause_in,
        output ready_out, data_out, valid_out, sel_out, word_cnt
    );
endinterface

// File: rtl/demux_rr.sv
// ----------------------------------------------------------------------------
// demux_rr
//   Parametrised 1:N round-robin demultiplexer. Consecutive accepted words go
//   to lanes in cyclic order starting from the pointer; paused lanes are
//   skipped, and upstream sees ready_out low only when every lane is paused.
//   Lane data, strobes, pointer and word counter are all registered
//   (latency 1 cycle).
//
//   Ports
//     clk      rising-edge clock
//     reset_L  asynchronous active-low reset
//     bus      demux_rr_if.slave (handshake, pause, lane outputs, status)
// ----------------------------------------------------------------------------
module demux_rr #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 2
) (
    input logic       clk,
    input logic       reset_L,
    demux_rr_if.slave bus
);
    localparam int               PTR_W = (N_OUT > 2) ? $clog2(N_OUT) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_OUT - 1);

    logic [N_OUT-1:0][DATA_W-1:0] r_data;
    logic [N_OUT-1:0]             r_valid;
    logic [PTR_W-1:0]             r_sel;
    logic [15:0]                  r_cnt;

    logic                         w_ready;
    logic                         w_xfer;
    logic                         w_found;
    logic [PTR_W-1:0]             w_dest;
    logic [PTR_W:0]               w_idx;

    assign w_ready = reset_L & ~(&bus.pause_in);
    assign w_xfer  = bus.valid_in & w_ready;

    // First unpaused lane searching upward from the pointer with wrap.
    // The extra index bit holds sel+k before folding it back below N_OUT,
    // which keeps the search correct for non-power-of-two lane counts.
    always_comb begin
        w_found = 1'b0;
        w_dest  = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            w_idx = {1'b0, r_sel} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(N_OUT)) begin
                w_idx = w_idx - (PTR_W+1)'(N_OUT);
            end
            if (!w_found && !bus.pause_in[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_dest  = w_idx[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_data  <= '0;
            r_valid <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else if (w_xfer) begin
            r_data[w_dest] <= bus.data_in;
            r_valid        <= {{(N_OUT-1){1'b0}}, 1'b1} << w_dest;
            r_sel          <= (w_dest == LAST) ? '0 : w_dest + 1'b1;
            if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end else begin
            // Lane data holds; only the strobe drops.
            r_valid <= '0;
        end
    end

    assign bus.ready_out = w_ready;
    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign bus.sel_out   = r_sel;
    assign bus.word_cnt  = r_cnt;
endmodule
